// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: registers decoded instruction fields, and forwards
// rs/rt from EX/MEM and MEM/WB (EX/MEM first). Drives the ALU operands and
// the EX-stage control signals.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [5:0]  id_opcode,
    input  logic [5:0]  id_funct,
    input  logic [4:0]  id_shamt,
    input  logic [15:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        exmem_regwrite,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_regwrite,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        ex_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_c,
    output logic [4:0]  ex_dest,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic [31:0] ex_store_data,
    output logic        ex_illegal
);

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_LUI = 4'b1010;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
        return {16'b0, imm};
    endfunction

    // Newest producer wins; r0 is hard-wired and never forwarded.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  idx,
        input logic [31:0] data,
        input logic        em_we,
        input logic [4:0]  em_rd,
        input logic [31:0] em_res,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_res
    );
        if (em_we && (em_rd != 5'd0) && (em_rd == idx))
            return em_res;
        else if (mw_we && (mw_rd != 5'd0) && (mw_rd == idx))
            return mw_res;
        else
            return data;
    endfunction

    // Decoded control, captured into the stage registers
    logic [3:0]  d_alu_c;
    logic        d_a_rt;
    logic        d_b_rt;
    logic [31:0] d_b_const;
    logic [4:0]  d_dest;
    logic        d_regwrite;
    logic        d_memread;
    logic        d_memwrite;
    logic        d_illegal;

    // Stage registers
    logic        vld_p1;
    logic [4:0]  rs_p1;
    logic [4:0]  rt_p1;
    logic [31:0] rs_data_p1;
    logic [31:0] rt_data_p1;
    logic [31:0] b_const_p1;
    logic [3:0]  alu_c_p1;
    logic        a_rt_p1;
    logic        b_rt_p1;
    logic [4:0]  dest_p1;
    logic        regwrite_p1;
    logic        memread_p1;
    logic        memwrite_p1;
    logic        illegal_p1;

    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Instruction decode of the ID-stage fields
    always_comb begin
        d_alu_c    = ALU_ADD;
        d_a_rt     = 1'b0;
        d_b_rt     = 1'b1;
        d_b_const  = 32'd0;
        d_dest     = 5'd0;
        d_regwrite = 1'b0;
        d_memread  = 1'b0;
        d_memwrite = 1'b0;
        d_illegal  = 1'b0;
        case (id_opcode)
            6'h00: begin
                case (id_funct)
                    6'h20: begin
                        d_dest     = id_rd;
                        d_regwrite = 1'b1;
                    end
                    6'h22: begin
                        d_alu_c    = ALU_SUB;
                        d_dest     = id_rd;
                        d_regwrite = 1'b1;
                    end
                    6'h18: begin
                        d_alu_c    = ALU_MUL;
                        d_dest     = id_rd;
                        d_regwrite = 1'b1;
                    end
                    6'h02: begin
                        d_alu_c    = ALU_SRL;
                        d_a_rt     = 1'b1;
                        d_b_rt     = 1'b0;
                        d_b_const  = {27'd0, id_shamt};
                        d_dest     = id_rd;
                        d_regwrite = 1'b1;
                    end
                    default: d_illegal = 1'b1;
                endcase
            end
            6'h08: begin
                d_b_rt     = 1'b0;
                d_b_const  = sign_ext16(id_imm);
                d_dest     = id_rt;
                d_regwrite = 1'b1;
            end
            6'h0F: begin
                d_alu_c    = ALU_LUI;
                d_b_rt     = 1'b0;
                d_b_const  = zero_ext16(id_imm);
                d_dest     = id_rt;
                d_regwrite = 1'b1;
            end
            6'h23: begin
                d_b_rt     = 1'b0;
                d_b_const  = sign_ext16(id_imm);
                d_dest     = id_rt;
                d_regwrite = 1'b1;
                d_memread  = 1'b1;
            end
            6'h2B: begin
                d_b_rt     = 1'b0;
                d_b_const  = sign_ext16(id_imm);
                d_memwrite = 1'b1;
            end
            6'h04: begin
                d_alu_c    = ALU_SUB;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // Stage register update: reset > flush > stall hold > bubble/capture
    always_ff @(posedge clk) begin
        if (!rst_n || flush || (!stall && !id_valid)) begin
            vld_p1      <= 1'b0;
            rs_p1       <= 5'd0;
            rt_p1       <= 5'd0;
            rs_data_p1  <= 32'd0;
            rt_data_p1  <= 32'd0;
            b_const_p1  <= 32'd0;
            alu_c_p1    <= 4'd0;
            a_rt_p1     <= 1'b0;
            b_rt_p1     <= 1'b0;
            dest_p1     <= 5'd0;
            regwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
            memwrite_p1 <= 1'b0;
            illegal_p1  <= 1'b0;
        end else if (!stall) begin
            vld_p1      <= 1'b1;
            rs_p1       <= id_rs;
            rt_p1       <= id_rt;
            rs_data_p1  <= id_rs_data;
            rt_data_p1  <= id_rt_data;
            b_const_p1  <= d_b_const;
            alu_c_p1    <= d_alu_c;
            a_rt_p1     <= d_a_rt;
            b_rt_p1     <= d_b_rt;
            dest_p1     <= d_dest;
            regwrite_p1 <= d_regwrite;
            memread_p1  <= d_memread;
            memwrite_p1 <= d_memwrite;
            illegal_p1  <= d_illegal;
        end
    end

    // Forwarding stays live during stall so held operands pick up new results
    always_comb begin
        fwd_rs = fwd_sel(rs_p1, rs_data_p1, exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
        fwd_rt = fwd_sel(rt_p1, rt_data_p1, exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
    end

    // Operand and control outputs; a bubble presents 0 + 0 to the ALU
    always_comb begin
        ex_valid      = vld_p1;
        alu_a         = 32'd0;
        alu_b         = 32'd0;
        alu_c         = ALU_ADD;
        ex_dest       = 5'd0;
        ex_regwrite   = 1'b0;
        ex_memread    = 1'b0;
        ex_memwrite   = 1'b0;
        ex_store_data = 32'd0;
        ex_illegal    = 1'b0;
        if (vld_p1) begin
            alu_a         = a_rt_p1 ? fwd_rt : fwd_rs;
            alu_b         = b_rt_p1 ? fwd_rt : b_const_p1;
            alu_c         = alu_c_p1;
            ex_dest       = dest_p1;
            ex_regwrite   = regwrite_p1;
            ex_memread    = memread_p1;
            ex_memwrite   = memwrite_p1;
            ex_store_data = memwrite_p1 ? fwd_rt : 32'd0;
            ex_illegal    = illegal_p1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic,
// checked against an instruction-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_shamt;
    logic [15:0] id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic        stall, flush;
    logic        exmem_regwrite, memwb_regwrite;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        ex_valid;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_c;
    logic [4:0]  ex_dest;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_illegal;
    logic [31:0] ex_store_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_shamt(id_shamt), .id_imm(id_imm), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .stall(stall), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
    );

    // Instruction held by the stage in the reference model
    typedef struct {
        bit          v;
        logic [5:0]  op, funct;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd;
    } instr_t;

    instr_t held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] data);
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
        return data;
    endfunction

    // Model of the stage register update on a rising edge
    task automatic model_clock();
        instr_t bubble;
        bubble = '{v: 1'b0, op: 0, funct: 0, shamt: 0, imm: 0, rs: 0, rt: 0, rd: 0, rsd: 0, rtd: 0};
        if (!rst_n || flush) held = bubble;
        else if (stall) held = held;
        else if (!id_valid) held = bubble;
        else held = '{v: 1'b1, op: id_opcode, funct: id_funct, shamt: id_shamt, imm: id_imm,
                      rs: id_rs, rt: id_rt, rd: id_rd, rsd: id_rs_data, rtd: id_rt_data};
    endtask

    // Compare every output against what the held instruction should produce
    task automatic check_all();
        logic [31:0] e_a, e_b, e_sd, rsv, rtv, sx;
        logic [3:0]  e_c;
        logic [4:0]  e_dest;
        bit e_rw, e_mr, e_mw, e_ill, chk_b, chk_dest, chk_sd;
        string nm;
        rsv = fwd(held.rs, held.rsd);
        rtv = fwd(held.rt, held.rtd);
        sx  = {{16{held.imm[15]}}, held.imm};
        e_a = 0; e_b = 0; e_c = 4'b0010; e_dest = 0; e_sd = 0;
        e_rw = 0; e_mr = 0; e_mw = 0; e_ill = 0;
        chk_b = 1; chk_dest = 1; chk_sd = 1;
        nm = "bubble";
        if (held.v) begin
            e_a = rsv;
            chk_dest = 0;
            chk_sd = 0;
            if (held.op == 6'h00 && held.funct == 6'h20) begin
                nm = "add"; e_b = rtv; e_dest = held.rd; e_rw = 1; chk_dest = 1;
            end else if (held.op == 6'h00 && held.funct == 6'h22) begin
                nm = "sub"; e_c = 4'b0110; e_b = rtv; e_dest = held.rd; e_rw = 1; chk_dest = 1;
            end else if (held.op == 6'h00 && held.funct == 6'h18) begin
                nm = "mul"; e_c = 4'b1000; e_b = rtv; e_dest = held.rd; e_rw = 1; chk_dest = 1;
            end else if (held.op == 6'h00 && held.funct == 6'h02) begin
                nm = "srl"; e_c = 4'b1001; e_a = rtv; e_b = 32'(held.shamt);
                e_dest = held.rd; e_rw = 1; chk_dest = 1;
            end else if (held.op == 6'h08) begin
                nm = "addi"; e_b = sx; e_dest = held.rt; e_rw = 1; chk_dest = 1;
            end else if (held.op == 6'h0F) begin
                nm = "lui"; e_c = 4'b1010; e_b = 32'(held.imm); e_dest = held.rt; e_rw = 1; chk_dest = 1;
            end else if (held.op == 6'h23) begin
                nm = "lw"; e_b = sx; e_dest = held.rt; e_rw = 1; e_mr = 1; chk_dest = 1;
            end else if (held.op == 6'h2B) begin
                nm = "sw"; e_b = sx; e_mw = 1; e_sd = rtv; chk_sd = 1;
            end else if (held.op == 6'h04) begin
                nm = "beq"; e_c = 4'b0110; e_b = rtv;
            end else begin
                nm = "illegal"; e_ill = 1; chk_b = 0;
            end
        end
        check({nm, ".valid"},    32'(ex_valid),    32'(held.v));
        check({nm, ".alu_a"},    alu_a,            e_a);
        if (chk_b) check({nm, ".alu_b"}, alu_b, e_b);
        check({nm, ".alu_c"},    32'(alu_c),       32'(e_c));
        if (chk_dest) check({nm, ".dest"}, 32'(ex_dest), 32'(e_dest));
        check({nm, ".regwrite"}, 32'(ex_regwrite), 32'(e_rw));
        check({nm, ".memread"},  32'(ex_memread),  32'(e_mr));
        check({nm, ".memwrite"}, 32'(ex_memwrite), 32'(e_mw));
        if (chk_sd) check({nm, ".store"}, ex_store_data, e_sd);
        check({nm, ".illegal"},  32'(ex_illegal),  32'(e_ill));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #2;
        check_all();
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                             input logic [15:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
        id_valid = 1; id_opcode = op; id_funct = fn; id_shamt = sh; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
    endtask

    task automatic no_fwd();
        exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] fns [5];
        ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h3F, 6'h11};
        fns = '{6'h20, 6'h22, 6'h18, 6'h02, 6'h07};
        held = '{v: 1'b0, op: 0, funct: 0, shamt: 0, imm: 0, rs: 0, rt: 0, rd: 0, rsd: 0, rtd: 0};

        rst_n = 0; stall = 0; flush = 0; no_fwd();
        set_instr(6'h00, 6'h20, 0, 0, 1, 2, 3, 32'h11, 32'h22);
        cycle();
        cycle();
        check("rst.alu_c", 32'(alu_c), 32'h2);
        check("rst.valid", 32'(ex_valid), 0);
        rst_n = 1;

        // add with plain register data
        set_instr(6'h00, 6'h20, 0, 0, 1, 2, 4, 32'h5, 32'h3);
        cycle();
        check("add.a5", alu_a, 32'h5);
        check("add.b3", alu_b, 32'h3);
        check("add.dest4", 32'(ex_dest), 4);

        // addi with negative immediate, then lui
        set_instr(6'h08, 0, 0, 16'hFFFE, 1, 7, 0, 32'h10, 32'h0);
        cycle();
        check("addi.sext", alu_b, 32'hFFFF_FFFE);
        set_instr(6'h0F, 0, 0, 16'h1234, 0, 9, 0, 32'h0, 32'h0);
        cycle();
        check("lui.zext", alu_b, 32'h0000_1234);

        // srl shifts rt by shamt
        set_instr(6'h00, 6'h02, 5'd4, 0, 0, 3, 6, 32'h0, 32'h8000_0000);
        cycle();
        check("srl.a", alu_a, 32'h8000_0000);
        check("srl.b", alu_b, 32'h4);

        // forwarding priority while the stage is held
        set_instr(6'h00, 6'h20, 0, 0, 5, 0, 8, 32'h1, 32'h0);
        cycle();
        stall = 1;
        exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'hAA;
        memwb_regwrite = 1; memwb_rd = 5; memwb_result = 32'hBB;
        #1 check_all();
        check("fwd.exmem", alu_a, 32'hAA);
        exmem_regwrite = 0;
        #1 check_all();
        check("fwd.memwb", alu_a, 32'hBB);
        cycle();
        exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
        #1 check_all();
        check("fwd.r0", alu_b, 32'h0);
        stall = 0; no_fwd();
        set_instr(6'h00, 6'h20, 0, 0, 0, 0, 8, 32'h0, 32'h0);
        exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
        cycle();
        check("r0.a", alu_a, 32'h0);
        no_fwd();

        // sub held through stall, then stall+flush
        set_instr(6'h00, 6'h22, 0, 0, 2, 3, 10, 32'h50, 32'h20);
        cycle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            set_instr(6'h08, 0, 0, 16'(i), 4, 5, 6, 32'h7, 32'h7);
            cycle();
            check("stall.c", 32'(alu_c), 32'h6);
        end
        flush = 1;
        cycle();
        check("flush.valid", 32'(ex_valid), 0);
        flush = 0; stall = 0;

        // illegal opcode, then reset during stall
        set_instr(6'h3F, 0, 0, 0, 1, 2, 3, 32'h1, 32'h2);
        cycle();
        check("ill.flag", 32'(ex_illegal), 1);
        set_instr(6'h2B, 0, 0, 16'h8000, 1, 2, 0, 32'h100, 32'hCAFE);
        cycle();
        stall = 1; rst_n = 0;
        cycle();
        check("rststall.valid", 32'(ex_valid), 0);
        check("rststall.sd", ex_store_data, 0);
        stall = 0; rst_n = 1;

        // randomized traffic with forwarding on a small register set
        for (int i = 0; i < 600; i++) begin
            set_instr(ops[$urandom_range(0, 9)], fns[$urandom_range(0, 4)],
                      5'($urandom), 16'($urandom), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom);
            id_valid       = ($urandom_range(0, 99) < 85);
            stall          = ($urandom_range(0, 99) < 20);
            flush          = ($urandom_range(0, 99) < 10);
            rst_n          = ($urandom_range(0, 99) >= 3);
            exmem_regwrite = 1'($urandom);
            exmem_rd       = 5'($urandom_range(0, 7));
            exmem_result   = $urandom;
            memwb_regwrite = 1'($urandom);
            memwb_rd       = 5'($urandom_range(0, 7));
            memwb_result   = $urandom;
            cycle();
            exmem_result = $urandom;
            exmem_rd     = 5'($urandom_range(0, 7));
            #1 check_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous, active-low reset.
REQ-002 SHALL have decode inputs: id_valid 1, id_opcode 6, id_funct 6, id_shamt 5, id_imm 16, id_rs 5, id_rt 5, id_rd 5, id_rs_data 32, id_rt_data 32.
REQ-003 SHALL have pipeline controls: stall  in  1  hold stage; flush  in  1  insert bubble.
REQ-004 SHALL have forwarding inputs: exmem_regwrite 1, exmem_rd 5, exmem_result 32, memwb_regwrite 1, memwb_rd 5, memwb_result 32.
REQ-005 SHALL have outputs: ex_valid 1; alu_a 32; alu_b 32; alu_c 4; ex_dest 5; ex_regwrite 1; ex_memread 1; ex_memwrite 1; ex_store_data 32; ex_illegal 1.
REQ-006 alu_a, alu_b, alu_c SHALL connect directly to the ALU A, B and alu_C inputs.

Function
REQ-007 On each rising clk with rst_n=1, flush=0, stall=0: SHALL register all id_* inputs and decoded control into the stage.
REQ-008 stall=1, flush=0: SHALL hold every stage register unchanged.
REQ-009 flush=1: SHALL load a bubble (valid, regwrite, memread, memwrite, illegal = 0; other fields 0); flush SHALL override stall.
REQ-010 id_valid=0 captured: SHALL load a bubble identically to REQ-009.
REQ-011 Decode (registered, 1-cycle latency), opcode 0x00: funct 0x20 add -> alu_c 0010; 0x22 sub -> 0110; 0x18 mul -> 1000; 0x02 srl -> 1001; dest=rd, regwrite=1.
REQ-012 opcode 0x08 addi -> 0010, B=sign-ext imm, dest=rt, regwrite=1.
REQ-013 opcode 0x0F lui -> 1010, B=zero-ext imm, dest=rt, regwrite=1.
REQ-014 opcode 0x23 lw -> 0010, B=sign-ext imm, dest=rt, regwrite=1, memread=1.
REQ-015 opcode 0x2B sw -> 0010, B=sign-ext imm, regwrite=0, memwrite=1, ex_store_data=forwarded rt.
REQ-016 opcode 0x04 beq -> 0110, B=forwarded rt, regwrite=0.
REQ-017 Any other opcode/funct with id_valid=1: ex_valid=1, alu_c 0010, regwrite=memread=memwrite=0, ex_illegal=1.
REQ-018 A operand: forwarded rs for all ops except srl, where alu_a SHALL be forwarded rt.
REQ-019 srl B operand: SHALL be {27'b0, shamt}.
REQ-020 R-type add/sub/mul B operand: SHALL be forwarded rt.
REQ-021 Forwarding SHALL be combinational on the registered rs/rt index and data: exmem_result if exmem_regwrite=1, exmem_rd!=0 and exmem_rd==index; else memwb_result under the same conditions with memwb_*; else the registered data.
REQ-022 EX/MEM match SHALL take priority over MEM/WB when both match.
REQ-023 Index 0 SHALL never be forwarded; alu operand from r0 SHALL be the registered data.
REQ-024 While ex_valid=0: alu_a, alu_b SHALL be 0 and alu_c SHALL be 0010 (ALU zero flag then 1; downstream SHALL qualify with ex_valid).
REQ-025 Forwarding SHALL remain active during stall, so held operands track updated later-stage results.
REQ-026 Sign extension SHALL replicate imm[15] into bits 31:16; zero extension SHALL fill 0.

Reset
REQ-027 rst_n=0 at a rising clk SHALL clear every stage register to 0, overriding stall and flush; ex_valid=0, ex_regwrite=0, ex_memread=0, ex_memwrite=0, ex_illegal=0, ex_dest=0, alu_c=0010, alu_a=alu_b=ex_store_data=0.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction; first post-reset capture occurs on the first clk with rst_n=1.

Verification
REQ-029 add rs=1(0x5), rt=2(0x3), rd=4, no forwarding -> next cycle alu_a=5, alu_b=3, alu_c=0010, ex_dest=4, ex_regwrite=1.
REQ-030 addi rs=1(0x10), imm=0xFFFE -> alu_b=0xFFFFFFFE, alu_c=0010, ex_dest=rt; lui imm=0x1234 -> alu_b=0x00001234, alu_c=1010.
REQ-031 srl rt=3(0x80000000), shamt=4 -> alu_a=0x80000000, alu_b=4, alu_c=1001.
REQ-032 Stage holds rs=5; exmem_rd=5/0xAA and memwb_rd=5/0xBB both writing -> alu_a=0xAA; drop exmem_regwrite -> 0xBB; rs=0 with rd=0 matches -> no forwarding.
REQ-033 Capture sub, assert stall 3 cycles with new id inputs -> outputs unchanged; assert stall+flush -> next cycle ex_valid=0, ex_regwrite=0.
REQ-034 Opcode 0x3F valid -> ex_illegal=1, ex_regwrite=0; rst_n=0 during stall -> next cycle all outputs at REQ-027 values.
